// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// Holds the FSM state encoding, the statistics counter width and the
// round-robin pick function used by the priority picker.
package fifo_wr_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    localparam int STAT_WIDTH = 16;
    localparam int MAX_REQ    = 16;

    typedef struct packed {
        logic        found;
        logic [31:0] idx;
    } pick_t;

    // Rotate the request vector so 'start' lands at bit 0, take the lowest
    // set bit, then map that position back to the original requester index.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                      input int                 start,
                                      input int                 numReq);
        logic [MAX_REQ-1:0] rotated;
        logic [3:0]         pos;
        pick_t              result;
        rotated = '0;
        result  = '0;
        pos     = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (i < numReq) begin
                pos        = 4'((start + i) % numReq);
                rotated[i] = valid[pos];
            end
        end
        for (int i = MAX_REQ - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                result.found = 1'b1;
                result.idx   = 32'((start + i) % numReq);
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_picker.sv
// Combinational round-robin priority picker: returns the first set request
// at or above start_i, wrapping around, together with a found flag.
module rr_priority_picker
    import fifo_wr_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]  valid_i,
    input  logic [ID_WIDTH-1:0] start_i,
    output logic                found_o,
    output logic [ID_WIDTH-1:0] idx_o
);

    pick_t pick;

    // Rotate, priority-encode and un-rotate in one combinational step.
    always_comb begin
        pick    = rr_pick(MAX_REQ'(valid_i), int'(start_i), NUM_REQ);
        found_o = pick.found;
        idx_o   = ID_WIDTH'(pick.idx);
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// A grantee keeps the port for up to BURST_LEN beats or until it goes idle;
// the next grantee is chosen in the same cycle so bursts chain without a
// bubble. New grants are withheld while the FIFO is almost full.
// Optional per-requester transfer statistics: define FIFO_WR_ARB_STATS_EN.
module fifo_wr_arbiter
    import fifo_wr_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4,
    parameter int ID_WIDTH   = $clog2(NUM_REQ),
    parameter int CNT_WIDTH  = $clog2(BURST_LEN + 1)
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [NUM_REQ-1:0]            i_valid_req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_data_req,
    output logic [NUM_REQ-1:0]            o_ready_req,
    input  logic                          i_fifo_ready,
    input  logic                          i_fifo_almostfull,
    output logic                          o_fifo_valid,
    output logic [DATA_WIDTH-1:0]         o_fifo_data,
    output logic [ID_WIDTH-1:0]           o_grant_id,
`ifdef FIFO_WR_ARB_STATS_EN
    input  logic [ID_WIDTH-1:0]           i_stat_sel,
    input  logic                          i_stat_clr,
    output logic [STAT_WIDTH-1:0]         o_stat_cnt,
`endif
    output logic                          o_busy
);

    state_e                state_q, state_d;
    logic [ID_WIDTH-1:0]   grantId_q, grantId_d;
    logic [ID_WIDTH-1:0]   ptr_q, ptr_d;
    logic [CNT_WIDTH-1:0]  beatCnt_q, beatCnt_d;

    logic                  pickFound;
    logic [ID_WIDTH-1:0]   pickIdx;
    logic [ID_WIDTH-1:0]   pickNext;
    logic                  granted;
    logic                  grantValid;
    logic [DATA_WIDTH-1:0] grantData;
    logic                  xfer;
    logic                  lastBeat;
    logic                  releaseGrant;

    // The pointer is kept at grantee+1 while granted, so the single picker
    // serves both the IDLE search and the release-cycle search, and the
    // current grantee naturally comes last in the rotation.
    rr_priority_picker #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_picker (
        .valid_i (i_valid_req),
        .start_i (ptr_q),
        .found_o (pickFound),
        .idx_o   (pickIdx)
    );

    assign pickNext     = (pickIdx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : pickIdx + 1'b1;
    assign granted      = (state_q == ST_GRANT);
    assign grantValid   = i_valid_req[grantId_q];
    assign grantData    = i_data_req[grantId_q*DATA_WIDTH +: DATA_WIDTH];
    assign xfer         = granted & grantValid & i_fifo_ready;
    assign lastBeat     = xfer & (beatCnt_q == CNT_WIDTH'(BURST_LEN - 1));
    assign releaseGrant = granted & (~grantValid | lastBeat);

    // Next-state logic: grant from IDLE, count beats, and on release hand
    // the port straight to the next requester when allowed.
    always_comb begin
        state_d   = state_q;
        grantId_d = grantId_q;
        ptr_d     = ptr_q;
        beatCnt_d = beatCnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pickFound && !i_fifo_almostfull) begin
                    state_d   = ST_GRANT;
                    grantId_d = pickIdx;
                    ptr_d     = pickNext;
                    beatCnt_d = '0;
                end
            end
            ST_GRANT: begin
                if (xfer) begin
                    beatCnt_d = beatCnt_q + 1'b1;
                end
                if (releaseGrant) begin
                    beatCnt_d = '0;
                    if (pickFound && !i_fifo_almostfull) begin
                        grantId_d = pickIdx;
                        ptr_d     = pickNext;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, grant index, rotation pointer and beat counter registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            grantId_q <= '0;
            ptr_q     <= '0;
            beatCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            grantId_q <= grantId_d;
            ptr_q     <= ptr_d;
            beatCnt_q <= beatCnt_d;
        end
    end

    // Forward the grantee's handshake and data to the FIFO; all quiet in IDLE.
    always_comb begin
        o_fifo_valid = 1'b0;
        o_fifo_data  = '0;
        o_ready_req  = '0;
        if (granted) begin
            o_fifo_valid           = grantValid;
            o_fifo_data            = grantData;
            o_ready_req[grantId_q] = i_fifo_ready;
        end
    end

    assign o_grant_id = grantId_q;
    assign o_busy     = granted;

`ifdef FIFO_WR_ARB_STATS_EN
    logic [STAT_WIDTH-1:0] statCnt_q [NUM_REQ];

    // Saturating per-requester beat counters; a clear beats an increment.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < NUM_REQ; k++) statCnt_q[k] <= '0;
        end else if (i_stat_clr) begin
            for (int k = 0; k < NUM_REQ; k++) statCnt_q[k] <= '0;
        end else if (xfer && (statCnt_q[grantId_q] != '1)) begin
            statCnt_q[grantId_q] <= statCnt_q[grantId_q] + 1'b1;
        end
    end

    assign o_stat_cnt = statCnt_q[i_stat_sel];
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=8,
// BURST_LEN=4). Directed scenarios plus a randomized run against a
// cycle-level behavioural model. Statistics checks need FIFO_WR_ARB_STATS_EN.
module tb_fifo_wr_arbiter;

    localparam int NUM = 4;
    localparam int DW  = 8;
    localparam int BL  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [3:0]    vReq = '0;
    logic [31:0]   dReq = '0;
    logic          rdy = 1'b0;
    logic          af = 1'b0;
    logic [1:0]    statSel = '0;
    logic          statClr = 1'b0;
    logic [3:0]    readyReq;
    logic          fifoValid;
    logic [7:0]    fifoData;
    logic [1:0]    grantId;
    logic          busy;
    logic [15:0]   statCnt;

    int testsRun = 0;
    int testsFailed = 0;

    // behavioural model state
    bit mBusy;
    int mG, mPtr, mCnt, lastAcc;
    int mStat[NUM];

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NUM_REQ(NUM), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_valid_req       (vReq),
        .i_data_req        (dReq),
        .o_ready_req       (readyReq),
        .i_fifo_ready      (rdy),
        .i_fifo_almostfull (af),
        .o_fifo_valid      (fifoValid),
        .o_fifo_data       (fifoData),
        .o_grant_id        (grantId),
`ifdef FIFO_WR_ARB_STATS_EN
        .i_stat_sel        (statSel),
        .i_stat_clr        (statClr),
        .o_stat_cnt        (statCnt),
`endif
        .o_busy            (busy)
    );

`ifndef FIFO_WR_ARB_STATS_EN
    assign statCnt = '0;
`endif

    // first valid requester at or after s, wrapping; -1 when none
    function automatic int pickFrom(int s);
        int idx;
        for (int k = 0; k < NUM; k++) begin
            idx = (s + k) % NUM;
            if (vReq[idx]) return idx;
        end
        return -1;
    endfunction

    // advance the model by one clock using the current inputs, then clock the DUT
    task automatic tick();
        bit x;
        int p;
        x = 1'b0;
        lastAcc = -1;
        if (mBusy) begin
            x = vReq[mG] && rdy;
            if (x) begin
                mCnt++;
                lastAcc = mG;
            end
            if (!vReq[mG] || mCnt == BL) begin
                mPtr = (mG + 1) % NUM;
                mCnt = 0;
                p = pickFrom(mPtr);
                if (p >= 0 && !af) mG = p;
                else mBusy = 1'b0;
            end
        end else begin
            p = pickFrom(mPtr);
            if (p >= 0 && !af) begin
                mBusy = 1'b1;
                mG = p;
                mCnt = 0;
            end
        end
        if (statClr) begin
            for (int k = 0; k < NUM; k++) mStat[k] = 0;
        end else if (x && lastAcc >= 0 && mStat[lastAcc] < 65535) begin
            mStat[lastAcc]++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        vReq = '0; dReq = '0; rdy = 1'b0; af = 1'b0; statClr = 1'b0; statSel = '0;
        #2;
        rst_n = 1'b1;
        mBusy = 1'b0; mG = 0; mPtr = 0; mCnt = 0; lastAcc = -1;
        for (int k = 0; k < NUM; k++) mStat[k] = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        vReq = 4'b1111; rdy = 1'b1; dReq = 32'hDEADBEEF;
        #2;
        testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy: got %0h expected 0", busy); end
        testsRun++; if (fifoValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_valid: got %0h expected 0", fifoValid); end
        testsRun++; if (readyReq !== 4'b0) begin testsFailed++; $display("[TB] FAIL reset_ready: got %0h expected 0", readyReq); end
        testsRun++; if (fifoData !== 8'h0) begin testsFailed++; $display("[TB] FAIL reset_data: got %0h expected 0", fifoData); end
        testsRun++; if (grantId !== 2'd0) begin testsFailed++; $display("[TB] FAIL reset_grant: got %0h expected 0", grantId); end
        @(posedge clk);
        #1;
        testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_held_busy: got %0h expected 0", busy); end
        doReset();
        #1;
        testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL post_reset_busy: got %0h expected 0", busy); end
`ifdef FIFO_WR_ARB_STATS_EN
        testsRun++; if (statCnt !== 16'h0) begin testsFailed++; $display("[TB] FAIL reset_stat: got %0h expected 0", statCnt); end
`endif
    endtask

    task automatic test_single_requester();
        int sent = 0;
        rdy = 1'b1;
        for (int c = 0; c < 9; c++) begin
            vReq = (c < 7 && sent < 6) ? 4'b0010 : 4'b0000;
            dReq[15:8] = 8'(8'hA0 + sent);
            #1;
            if (c == 0 || c == 8) begin
                testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL single_idle_c%0d: got %0h expected 0", c, busy); end
            end else if (c == 7) begin
                testsRun++; if (busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL single_release: got %0h expected 1", busy); end
            end else begin
                testsRun++; if (fifoValid !== 1'b1 || grantId !== 2'd1) begin testsFailed++; $display("[TB] FAIL single_beat%0d: got valid %0h id %0h expected 1/1", c, fifoValid, grantId); end
                testsRun++; if (fifoData !== 8'(8'hA0 + sent)) begin testsFailed++; $display("[TB] FAIL single_data%0d: got %0h expected %0h", c, fifoData, 8'(8'hA0 + sent)); end
            end
            tick();
            if (lastAcc == 1) sent++;
        end
        testsRun++; if (sent !== 6) begin testsFailed++; $display("[TB] FAIL single_count: got %0d expected 6", sent); end
    endtask

    task automatic test_round_robin();
        int cnt[NUM];
        int xfers = 0;
        int expId;
        doReset();
        vReq = 4'b1111; rdy = 1'b1;
        for (int k = 0; k < NUM; k++) cnt[k] = 0;
        for (int c = 0; c < 40 && xfers < 20; c++) begin
            for (int k = 0; k < NUM; k++) dReq[k*8 +: 8] = {4'(k), 4'(cnt[k])};
            #1;
            if (busy) begin
                testsRun++; if ($countones(readyReq) != 1) begin testsFailed++; $display("[TB] FAIL rr_onehot: got %0b expected one-hot", readyReq); end
            end
            if (fifoValid && rdy) begin
                expId = (xfers / BL) % NUM;
                testsRun++; if (grantId !== 2'(expId) || fifoData[7:4] !== 4'(expId)) begin testsFailed++; $display("[TB] FAIL rr_order%0d: got id %0h data %0h expected id %0h", xfers, grantId, fifoData, expId); end
                xfers++;
            end
            tick();
            if (lastAcc >= 0) cnt[lastAcc]++;
        end
        testsRun++; if (xfers !== 20) begin testsFailed++; $display("[TB] FAIL rr_timeout: got %0d beats expected 20", xfers); end
        vReq = 4'b0000;
`ifdef FIFO_WR_ARB_STATS_EN
        for (int k = 0; k < NUM; k++) begin
            statSel = 2'(k);
            #1;
            testsRun++; if (statCnt !== 16'((k == 0) ? 8 : 4)) begin testsFailed++; $display("[TB] FAIL rr_stat%0d: got %0d expected %0d", k, statCnt, (k == 0) ? 8 : 4); end
        end
`endif
        tick();
    endtask

    task automatic test_stall();
        int n0 = 0, n1 = 0, obs0 = 0, stallLeft = 3;
        doReset();
        vReq = 4'b0011;
        for (int c = 0; c < 9; c++) begin
            rdy = !(n0 == 2 && stallLeft > 0);
            dReq[7:0] = 8'(8'h50 + n0);
            dReq[15:8] = 8'(8'h60 + n1);
            #1;
            if (!rdy) begin
                testsRun++; if (fifoValid !== 1'b1 || fifoData !== 8'h52 || readyReq !== 4'b0) begin testsFailed++; $display("[TB] FAIL stall_hold%0d: got valid %0h data %0h ready %0h expected 1/52/0", c, fifoValid, fifoData, readyReq); end
                stallLeft--;
            end
            if (fifoValid && rdy && grantId == 2'd0) obs0++;
            if (c == 8) begin
                testsRun++; if (grantId !== 2'd1 || busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL stall_handover: got id %0h busy %0h expected 1/1", grantId, busy); end
                testsRun++; if (obs0 !== 4) begin testsFailed++; $display("[TB] FAIL stall_burst: got %0d beats expected 4", obs0); end
            end
            tick();
            if (lastAcc == 0) n0++;
            if (lastAcc == 1) n1++;
        end
        vReq = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_almostfull();
        doReset();
        vReq = 4'b0100; af = 1'b1; rdy = 1'b1; dReq = 32'h00330000;
        for (int c = 0; c < 3; c++) begin
            #1;
            testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL af_nogrant%0d: got %0h expected 0", c, busy); end
            tick();
        end
        af = 1'b0;
        tick();
        #1;
        testsRun++; if (grantId !== 2'd2 || busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL af_grant: got id %0h busy %0h expected 2/1", grantId, busy); end
        af = 1'b1;
        for (int c = 0; c < BL; c++) begin
            #1;
            testsRun++; if (fifoValid !== 1'b1 || readyReq !== 4'b0100) begin testsFailed++; $display("[TB] FAIL af_burst%0d: got valid %0h ready %0h expected 1/4", c, fifoValid, readyReq); end
            tick();
        end
        #1;
        testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL af_release: got %0h expected 0", busy); end
        af = 1'b0;
        vReq = 4'b0000;
        tick();
    endtask

    task automatic test_handoff();
        doReset();
        vReq = 4'b1001; rdy = 1'b1; dReq = 32'h3300_0011;
        tick();
        #1;
        testsRun++; if (grantId !== 2'd0 || busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL handoff_first: got id %0h busy %0h expected 0/1", grantId, busy); end
        tick();
        vReq = 4'b1000;
        #1;
        testsRun++; if (fifoValid !== 1'b0 || busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL handoff_drop: got valid %0h busy %0h expected 0/1", fifoValid, busy); end
        tick();
        #1;
        testsRun++; if (grantId !== 2'd3 || fifoValid !== 1'b1 || fifoData !== 8'h33) begin testsFailed++; $display("[TB] FAIL handoff_next: got id %0h valid %0h data %0h expected 3/1/33", grantId, fifoValid, fifoData); end
        vReq = 4'b0000;
        tick();
    endtask

    task automatic test_reset_midburst();
        doReset();
        vReq = 4'b1110; rdy = 1'b1; dReq = 32'h44332211;
        tick();
        tick();
        #1;
        testsRun++; if (busy !== 1'b1 || grantId !== 2'd1) begin testsFailed++; $display("[TB] FAIL midrst_pre: got busy %0h id %0h expected 1/1", busy, grantId); end
        rst_n = 1'b0;
        #1;
        testsRun++; if (readyReq !== 4'b0 || fifoValid !== 1'b0 || busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL midrst_async: got ready %0h valid %0h busy %0h expected 0/0/0", readyReq, fifoValid, busy); end
        #1;
        rst_n = 1'b1;
        mBusy = 1'b0; mG = 0; mPtr = 0; mCnt = 0;
        for (int k = 0; k < NUM; k++) mStat[k] = 0;
        vReq = 4'b1111;
        tick();
        #1;
        testsRun++; if (grantId !== 2'd0 || busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL midrst_regrant: got id %0h busy %0h expected 0/1", grantId, busy); end
        vReq = 4'b0000;
        tick();
    endtask

    task automatic test_random();
        logic [7:0] expData;
        logic [3:0] expReady;
        doReset();
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < NUM; k++) begin
                if (!vReq[k] || lastAcc == k) begin
                    vReq[k] = ($urandom_range(0, 3) != 0);
                    dReq[k*8 +: 8] = 8'($urandom);
                end else if ($urandom_range(0, 15) == 0) begin
                    vReq[k] = 1'b0;
                end
            end
            rdy = ($urandom_range(0, 3) != 0);
            af = ($urandom_range(0, 4) == 0);
            statSel = 2'($urandom_range(0, 3));
            statClr = ($urandom_range(0, 49) == 0);
            #1;
            expData = mBusy ? dReq[mG*8 +: 8] : 8'h0;
            expReady = (mBusy && rdy) ? 4'(1 << mG) : 4'b0;
            testsRun++; if (busy !== mBusy) begin testsFailed++; $display("[TB] FAIL rnd_busy@%0d: got %0h expected %0h", c, busy, mBusy); end
            testsRun++; if (grantId !== 2'(mG)) begin testsFailed++; $display("[TB] FAIL rnd_grant@%0d: got %0h expected %0h", c, grantId, mG); end
            testsRun++; if (fifoValid !== (mBusy && vReq[mG])) begin testsFailed++; $display("[TB] FAIL rnd_valid@%0d: got %0h expected %0h", c, fifoValid, mBusy && vReq[mG]); end
            testsRun++; if (fifoData !== expData) begin testsFailed++; $display("[TB] FAIL rnd_data@%0d: got %0h expected %0h", c, fifoData, expData); end
            testsRun++; if (readyReq !== expReady) begin testsFailed++; $display("[TB] FAIL rnd_ready@%0d: got %0h expected %0h", c, readyReq, expReady); end
`ifdef FIFO_WR_ARB_STATS_EN
            testsRun++; if (statCnt !== 16'(mStat[statSel])) begin testsFailed++; $display("[TB] FAIL rnd_stat@%0d: got %0d expected %0d", c, statCnt, mStat[statSel]); end
`endif
            tick();
        end
        vReq = 4'b0000; statClr = 1'b0; af = 1'b0;
        tick();
        tick();
    endtask

`ifdef FIFO_WR_ARB_STATS_EN
    task automatic test_stats_saturate();
        doReset();
        vReq = 4'b0001; rdy = 1'b1;
        repeat (70000) tick();
        statSel = 2'd0;
        #1;
        testsRun++; if (statCnt !== 16'hFFFF) begin testsFailed++; $display("[TB] FAIL stat_saturate: got %0d expected 65535", statCnt); end
        statClr = 1'b1;
        tick();
        statClr = 1'b0;
        vReq = 4'b0000;
        for (int k = 0; k < NUM; k++) begin
            statSel = 2'(k);
            #1;
            testsRun++; if (statCnt !== 16'h0) begin testsFailed++; $display("[TB] FAIL stat_clear%0d: got %0d expected 0", k, statCnt); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_requester();
        test_round_robin();
        test_stall();
        test_almostfull();
        test_handoff();
        test_reset_midburst();
        test_random();
`ifdef FIFO_WR_ARB_STATS_EN
        test_stats_saturate();
`endif
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
